// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter and its users.
//   REG_ADDR_W / REG_DATA_W / NUM_REGS : register file geometry
//   wb_req_e                            : writeback requester indices
//   reg_addr_t                          : register address type
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;
  localparam int NUM_WB_REQ = 3;

  typedef enum logic [1:0] {
    REQ_ALU    = 2'd0,
    REQ_LOAD   = 2'd1,
    REQ_MULDIV = 2'd2
  } wb_req_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_wb_arbiter_chk.sv
// Protocol checker for the busy scoreboard.
//   Flags issue logic allocating a destination that still has a write outstanding.
//   A register being retired by the output stage in the same cycle may be
//   re-allocated immediately, since the set takes priority over the clear.
module regfile_wb_arbiter_chk #(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic                clk,
  input logic                rst,
  input logic                mark_valid,
  input logic [ADDR_W-1:0]   mark_addr,
  input logic                reg_write,
  input logic [ADDR_W-1:0]   write_reg,
  input logic [NUM_REGS-1:0] busy
);

  // Marking a busy register is an issue-logic bug unless it is retiring now.
  mark_busy_reg_a : assert property (@(posedge clk) disable iff (!rst)
    (mark_valid && (mark_addr != '0)) |->
      (!busy[mark_addr] || (reg_write && (write_reg == mark_addr))))
    else $error("mark of busy register r%0d", mark_addr);

endmodule

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter, reusable for any shared port.
//   req   : request vector, one bit per requester
//   ptr   : highest-priority index this cycle (search wraps modulo N)
//   grant : one-hot grant, or zero when no request is present
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant
);

  int               sum_s;
  logic [PTR_W-1:0] idx_s;
  logic             found_s;

  // Walk requesters starting at ptr; the first one asserting req wins.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    sum_s   = 0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = int'(ptr) + k;
      if (sum_s >= N) begin
        sum_s = sum_s - N;
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with busy scoreboard.
//   clk, rst              : clock and synchronous active-low reset
//   req_valid/ready/addr/data : NREQ writeback producers (valid/ready handshake)
//   mark_valid/mark_addr  : issue logic allocating a destination register
//   RegWrite/Write_reg/Write_data : registered regfile write port (latency 1)
//   busy                  : per-register outstanding-write scoreboard, bit 0 always 0
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ     = NUM_WB_REQ,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   mark_valid,
  input  logic [ADDR_W-1:0]      mark_addr,
  output logic                   RegWrite,
  output logic [ADDR_W-1:0]      Write_reg,
  output logic [DATA_W-1:0]      Write_data,
  output logic [NUM_REGS-1:0]    busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]    ptr_r;
  logic [PTR_W-1:0]    ptr_next_s;
  logic [PTR_W-1:0]    gnt_idx_s;
  logic [NREQ-1:0]     grant_s;
  logic [NREQ-1:0]     xfer_s;
  logic                xfer_any_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [NUM_REGS-1:0] busy_next_s;

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Grants are suppressed during reset so nothing is accepted and then lost silently.
  assign req_ready  = rst ? grant_s : '0;
  assign xfer_s     = req_valid & req_ready;
  assign xfer_any_s = |xfer_s;

  // Mux the winning requester's address/data and remember its index.
  always_comb begin
    gnt_idx_s  = '0;
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (xfer_s[i]) begin
        gnt_idx_s  = PTR_W'(i);
        sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
        sel_data_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // Priority moves to the requester just after the one that won.
  always_comb begin
    if (gnt_idx_s == PTR_W'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gnt_idx_s + PTR_W'(1);
    end
  end

  // Scoreboard update: clear on retire, then set on allocation so set wins.
  always_comb begin
    busy_next_s = busy;
    if (RegWrite) begin
      busy_next_s[Write_reg] = 1'b0;
    end else begin
      busy_next_s = busy_next_s;
    end
    if (mark_valid && (mark_addr != '0)) begin
      busy_next_s[mark_addr] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
  end

  // Pointer, output stage and scoreboard registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r      <= '0;
      RegWrite   <= 1'b0;
      Write_reg  <= '0;
      Write_data <= '0;
      busy       <= '0;
    end else begin
      if (xfer_any_s) begin
        ptr_r <= ptr_next_s;
      end
      // A write to r0 completes its handshake but never reaches the regfile.
      RegWrite <= xfer_any_s && (sel_addr_s != '0);
      if (xfer_any_s && (sel_addr_s != '0)) begin
        Write_reg  <= sel_addr_s;
        Write_data <= sel_data_s;
      end
      busy <= busy_next_s;
    end
  end

  regfile_wb_arbiter_chk #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .mark_valid (mark_valid),
    .mark_addr  (mark_addr),
    .reg_write  (RegWrite),
    .write_reg  (Write_reg),
    .busy       (busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        mark_valid;
  logic [4:0]  mark_addr;
  logic        RegWrite;
  logic [4:0]  Write_reg;
  logic [31:0] Write_data;
  logic [31:0] busy;

  int n_assert;
  int n_fail;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .mark_valid (mark_valid),
    .mark_addr  (mark_addr),
    .RegWrite   (RegWrite),
    .Write_reg  (Write_reg),
    .Write_data (Write_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    req_valid  = 3'b111;
    req_addr   = {5'd3, 5'd2, 5'd1};
    req_data   = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    mark_valid = 1'b0;
    mark_addr  = 5'd0;

    // 1 Reset with every requester asking
    tick();
    tick();
    check("rst_ready", {29'd0, req_ready}, 32'h0);
    check("rst_regwrite", {31'd0, RegWrite}, 32'h0);
    check("rst_busy", busy, 32'h0);
    rst = 1'b1;
    #1;
    check("first_grant_idx0", {29'd0, req_ready}, 32'h1);
    req_valid = 3'b000;
    #1;

    // 2 Single ALU write to a marked r5
    mark_valid = 1'b1;
    mark_addr  = 5'd5;
    tick();
    mark_valid = 1'b0;
    check("mark_r5_busy", {31'd0, busy[5]}, 32'h1);
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd5};
    req_data  = {32'h0, 32'h0, 32'hDEAD_BEEF};
    #1;
    check("single_ready", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b000;
    check("single_regwrite", {31'd0, RegWrite}, 32'h1);
    check("single_wreg", {27'd0, Write_reg}, 32'd5);
    check("single_wdata", Write_data, 32'hDEAD_BEEF);
    check("single_busy_pending", {31'd0, busy[5]}, 32'h1);
    tick();
    check("single_busy_cleared", {31'd0, busy[5]}, 32'h0);
    check("single_idle_regwrite", {31'd0, RegWrite}, 32'h0);

    // Pointer now at 1; a MULDIV-only transfer returns it to 0
    req_valid = 3'b100;
    req_addr  = {5'd4, 5'd0, 5'd0};
    req_data  = {32'h4444_4444, 32'h0, 32'h0};
    #1;
    check("muldiv_only_ready", {29'd0, req_ready}, 32'h4);
    tick();
    req_valid = 3'b000;

    // 3 Round robin with all three valid
    req_valid = 3'b111;
    req_addr  = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_ready", {29'd0, req_ready}, 32'h1 << (c % 3));
      tick();
      check("rr_regwrite", {31'd0, RegWrite}, 32'h1);
      check("rr_wreg", {27'd0, Write_reg}, 32'((c % 3) + 1));
      check("rr_wdata", Write_data, 32'hA000_0000 + 32'(c % 3));
    end
    req_valid = 3'b000;

    // 4 LOAD writes r0 while issue marks r0
    req_valid  = 3'b010;
    req_addr   = {5'd0, 5'd0, 5'd0};
    req_data   = {32'h0, 32'h0000_1234, 32'h0};
    mark_valid = 1'b1;
    mark_addr  = 5'd0;
    #1;
    check("zero_ready", {29'd0, req_ready}, 32'h2);
    tick();
    req_valid  = 3'b000;
    mark_valid = 1'b0;
    check("zero_regwrite", {31'd0, RegWrite}, 32'h0);
    check("zero_busy", busy, 32'h0);

    // 5 r7 retired and re-marked in the same cycle
    mark_valid = 1'b1;
    mark_addr  = 5'd7;
    tick();
    mark_valid = 1'b0;
    check("r7_busy", busy, 32'h0000_0080);
    req_valid = 3'b001;
    req_addr  = {5'd0, 5'd0, 5'd7};
    req_data  = {32'h0, 32'h0, 32'h7777_7777};
    #1;
    check("r7_ready_wrap", {29'd0, req_ready}, 32'h1);
    tick();
    req_valid  = 3'b000;
    mark_valid = 1'b1;
    mark_addr  = 5'd7;
    check("r7_regwrite", {31'd0, RegWrite}, 32'h1);
    tick();
    mark_valid = 1'b0;
    check("setclr_set_wins", busy, 32'h0000_0080);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    tick();
    check("r7_final_clear", busy, 32'h0);

    // 6 Reset right after an accepted LOAD transfer
    mark_valid = 1'b1;
    mark_addr  = 5'd9;
    tick();
    mark_valid = 1'b0;
    req_valid  = 3'b010;
    req_addr   = {5'd0, 5'd9, 5'd0};
    req_data   = {32'h0, 32'h9999_9999, 32'h0};
    #1;
    check("midrst_ready", {29'd0, req_ready}, 32'h2);
    tick();
    rst       = 1'b0;
    req_valid = 3'b111;
    #1;
    check("midrst_ready_forced", {29'd0, req_ready}, 32'h0);
    tick();
    check("midrst_regwrite", {31'd0, RegWrite}, 32'h0);
    check("midrst_busy", busy, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst_ptr0", {29'd0, req_ready}, 32'h1);
    req_valid = 3'b000;
    tick();
    check("midrst_idle_regwrite", {31'd0, RegWrite}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
